// File: rtl/seq_identifier.sv
// Integer-sequence identifier: eight predictors run in lockstep with the input stream and
// are eliminated on mismatch; the stream locks when a single candidate survives long enough.
module seq_identifier #(
    parameter int LOCK_TERMS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic [7:0] match_mask,
    output logic [2:0] seq_id,
    output logic       locked,
    output logic       fail,
    output logic       err_pulse,
    output logic [7:0] term_count
);

    typedef enum logic [1:0] {ST_HUNT, ST_LOCKED, ST_FAIL} state_t;

    localparam logic [7:0] LOCK_TERMS_L = 8'(LOCK_TERMS);

    // Term-0 window per predictor, predictor 7 in the top byte.
    // t0 is the expected term; t1/t2 hold recurrence history or running increments.
    localparam logic [63:0] T0_INIT = {8'd2, 8'd1, 8'd2, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
    localparam logic [63:0] T1_INIT = {8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1};
    localparam logic [63:0] T2_INIT = {8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    state_t     r_state, w_state_next;
    logic [7:0] r_t0 [8];
    logic [7:0] r_t1 [8];
    logic [7:0] r_t2 [8];
    logic [7:0] w_n0 [8];
    logic [7:0] w_n1 [8];
    logic [7:0] w_n2 [8];

    logic [7:0] r_mask, r_cnt;
    logic [2:0] r_seq_id;
    logic       r_locked, r_fail, r_err;

    logic [7:0] w_hit, w_mask_upd, w_mask_next, w_cnt_upd;
    logic       w_accept, w_one_hot;
    logic [2:0] w_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_hit
            assign w_hit[gi] = (in_data == r_t0[gi]);
        end
    endgenerate

    assign w_accept    = in_valid && (r_state != ST_FAIL);
    assign w_mask_upd  = r_mask & w_hit;
    assign w_mask_next = w_accept ? w_mask_upd : r_mask;
    assign w_cnt_upd   = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
    assign w_one_hot   = (w_mask_upd != 8'h00) && ((w_mask_upd & (w_mask_upd - 8'd1)) == 8'h00);

    // Next term of every predictor, all arithmetic wrapping at 8 bits.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_n0[i] = r_t0[i];
            w_n1[i] = r_t1[i];
            w_n2[i] = r_t2[i];
        end
        w_n0[0] = r_t0[0] + r_t1[0];            // squares: add next odd number
        w_n1[0] = r_t1[0] + 8'd2;
        w_n0[1] = r_t0[1] * 8'd3;
        w_n0[2] = r_t0[2] + r_t1[2];            // triangular: add n+1
        w_n1[2] = r_t1[2] + 8'd1;
        w_n0[3] = r_t1[3];
        w_n1[3] = r_t0[3] + r_t1[3];
        w_n0[4] = r_t1[4];
        w_n1[4] = (r_t1[4] << 1) + r_t0[4];
        w_n0[5] = r_t1[5];
        w_n1[5] = r_t0[5] + r_t1[5];
        w_n0[6] = r_t1[6];                      // Padovan keeps a three-term window
        w_n1[6] = r_t2[6];
        w_n2[6] = r_t0[6] + r_t1[6];
        w_n0[7] = r_t0[7] * (r_t0[7] - 8'd1) + 8'd1;
    end

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_mask_next[i]) w_idx = 3'(i);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_accept) begin
                    if (w_mask_upd == 8'h00)
                        w_state_next = ST_FAIL;
                    else if (w_one_hot && (w_cnt_upd >= LOCK_TERMS_L))
                        w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_accept && (w_mask_upd == 8'h00)) w_state_next = ST_FAIL;
            end
            default: w_state_next = ST_FAIL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) r_state <= ST_HUNT;
        else                r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_mask   <= 8'hFF;
            r_cnt    <= 8'd0;
            r_seq_id <= 3'd0;
            r_locked <= 1'b0;
            r_fail   <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_t0[i] <= T0_INIT[i*8 +: 8];
                r_t1[i] <= T1_INIT[i*8 +: 8];
                r_t2[i] <= T2_INIT[i*8 +: 8];
            end
        end else begin
            r_err    <= w_accept && (w_mask_upd == 8'h00);
            r_locked <= (w_state_next == ST_LOCKED);
            r_fail   <= (w_state_next == ST_FAIL);
            r_seq_id <= (w_state_next == ST_LOCKED) ? w_idx : 3'd0;
            if (w_accept) begin
                r_mask <= w_mask_upd;
                r_cnt  <= w_cnt_upd;
                for (int i = 0; i < 8; i++) begin
                    r_t0[i] <= w_n0[i];
                    r_t1[i] <= w_n1[i];
                    r_t2[i] <= w_n2[i];
                end
            end
        end
    end

    assign match_mask = r_mask;
    assign term_count = r_cnt;
    assign seq_id     = r_seq_id;
    assign locked     = r_locked;
    assign fail       = r_fail;
    assign err_pulse  = r_err;

endmodule

// File: tb/tb_seq_identifier.sv
// Directed bench for seq_identifier: a default-parameter instance (A) and a LOCK_TERMS=1
// instance (B); expected outputs are queued per step and compared one cycle later.
module tb_seq_identifier;

    logic       clk;
    logic       a_reset, a_clear, a_valid;
    logic [7:0] a_data;
    logic [7:0] a_mask, a_cnt;
    logic [2:0] a_id;
    logic       a_lk, a_fl, a_er;
    logic       b_reset, b_clear, b_valid;
    logic [7:0] b_data;
    logic [7:0] b_mask, b_cnt;
    logic [2:0] b_id;
    logic       b_lk, b_fl, b_er;

    typedef struct {
        bit         sel;
        logic [7:0] mask;
        logic [2:0] id;
        logic       lk;
        logic       fl;
        logic       er;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    seq_identifier dut_a (
        .clk(clk), .reset(a_reset), .clear(a_clear), .in_valid(a_valid), .in_data(a_data),
        .match_mask(a_mask), .seq_id(a_id), .locked(a_lk), .fail(a_fl),
        .err_pulse(a_er), .term_count(a_cnt)
    );

    seq_identifier #(.LOCK_TERMS(1)) dut_b (
        .clk(clk), .reset(b_reset), .clear(b_clear), .in_valid(b_valid), .in_data(b_data),
        .match_mask(b_mask), .seq_id(b_id), .locked(b_lk), .fail(b_fl),
        .err_pulse(b_er), .term_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL s%0d %s observed=%0h expected=%0h", step_no, tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue its expected result, then compare after the edge.
    task automatic step(input bit sel, input bit rst, input bit clr, input bit vld,
                        input logic [7:0] d, input logic [7:0] m, input logic [2:0] id,
                        input logic lk, input logic fl, input logic er, input logic [7:0] cnt);
        exp_t e;
        if (sel == 1'b0) begin
            a_reset = rst; a_clear = clr; a_valid = vld; a_data = d;
        end else begin
            b_reset = rst; b_clear = clr; b_valid = vld; b_data = d;
        end
        e.sel = sel; e.mask = m; e.id = id; e.lk = lk; e.fl = fl; e.er = er; e.cnt = cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        a_reset = 1'b0; a_clear = 1'b0; a_valid = 1'b0;
        b_reset = 1'b0; b_clear = 1'b0; b_valid = 1'b0;
        step_no++;
        e = sb.pop_front();
        if (e.sel == 1'b0) begin
            chk("mask", a_mask, e.mask);
            chk("seq_id", 8'(a_id), 8'(e.id));
            chk("locked", 8'(a_lk), 8'(e.lk));
            chk("fail", 8'(a_fl), 8'(e.fl));
            chk("err_pulse", 8'(a_er), 8'(e.er));
            chk("term_count", a_cnt, e.cnt);
        end else begin
            chk("b_mask", b_mask, e.mask);
            chk("b_seq_id", 8'(b_id), 8'(e.id));
            chk("b_locked", 8'(b_lk), 8'(e.lk));
            chk("b_fail", 8'(b_fl), 8'(e.fl));
            chk("b_err_pulse", 8'(b_er), 8'(e.er));
            chk("b_term_count", b_cnt, e.cnt);
        end
    endtask

    initial begin
        logic [7:0] sq;
        logic [7:0] ec;
        a_reset = 1'b1; a_clear = 1'b0; a_valid = 1'b0; a_data = 8'd0;
        b_reset = 1'b1; b_clear = 1'b0; b_valid = 1'b0; b_data = 8'd0;

        // Reset state
        step(0, 1, 0, 0, 8'd0,   8'hFF, 0, 0, 0, 0, 8'd0);
        step(1, 1, 0, 0, 8'd0,   8'hFF, 0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 8'd0,   8'hFF, 0, 0, 0, 0, 8'd0);

        // Squares 0,1,4,9 -> lock on predictor 0
        step(0, 0, 0, 1, 8'd0,   8'h15, 0, 0, 0, 0, 8'd1);
        step(0, 0, 0, 1, 8'd1,   8'h15, 0, 0, 0, 0, 8'd2);
        step(0, 0, 0, 1, 8'd4,   8'h01, 0, 0, 0, 0, 8'd3);
        step(0, 0, 0, 1, 8'd9,   8'h01, 0, 1, 0, 0, 8'd4);

        // Clear with a simultaneous sample while locked: sample discarded
        step(0, 0, 1, 1, 8'd16,  8'hFF, 0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 8'd0,   8'hFF, 0, 0, 0, 0, 8'd0);

        // Sylvester 2,3,7,43,15 then a mismatch while locked
        step(0, 0, 0, 1, 8'd2,   8'hA0, 0, 0, 0, 0, 8'd1);
        step(0, 0, 0, 1, 8'd3,   8'h80, 0, 0, 0, 0, 8'd2);
        step(0, 0, 0, 1, 8'd7,   8'h80, 0, 0, 0, 0, 8'd3);
        step(0, 0, 0, 1, 8'd43,  8'h80, 7, 1, 0, 0, 8'd4);
        step(0, 0, 0, 1, 8'd15,  8'h80, 7, 1, 0, 0, 8'd5);
        step(0, 0, 0, 1, 8'd0,   8'h00, 0, 0, 1, 1, 8'd6);
        step(0, 0, 0, 0, 8'd0,   8'h00, 0, 0, 1, 0, 8'd6);

        // Elimination to empty: 1,1,2,4
        step(0, 1, 0, 0, 8'd0,   8'hFF, 0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 1, 8'd1,   8'h4A, 0, 0, 0, 0, 8'd1);
        step(0, 0, 0, 1, 8'd1,   8'h48, 0, 0, 0, 0, 8'd2);
        step(0, 0, 0, 1, 8'd2,   8'h08, 0, 0, 0, 0, 8'd3);
        step(0, 0, 0, 1, 8'd4,   8'h00, 0, 0, 1, 1, 8'd4);
        step(0, 0, 0, 0, 8'd0,   8'h00, 0, 0, 1, 0, 8'd4);
        step(0, 0, 0, 1, 8'd5,   8'h00, 0, 0, 1, 0, 8'd4);
        step(0, 0, 0, 1, 8'd3,   8'h00, 0, 0, 1, 0, 8'd4);
        step(0, 0, 1, 0, 8'd0,   8'hFF, 0, 0, 0, 0, 8'd0);

        // Powers of 3 with idle gaps
        step(0, 0, 0, 1, 8'd1,   8'h4A, 0, 0, 0, 0, 8'd1);
        step(0, 0, 0, 0, 8'd99,  8'h4A, 0, 0, 0, 0, 8'd1);
        step(0, 0, 0, 0, 8'd3,   8'h4A, 0, 0, 0, 0, 8'd1);
        step(0, 0, 0, 1, 8'd3,   8'h02, 0, 0, 0, 0, 8'd2);
        step(0, 0, 0, 0, 8'd9,   8'h02, 0, 0, 0, 0, 8'd2);
        step(0, 0, 0, 1, 8'd9,   8'h02, 0, 0, 0, 0, 8'd3);
        step(0, 0, 0, 1, 8'd27,  8'h02, 1, 1, 0, 0, 8'd4);
        step(0, 0, 0, 0, 8'd0,   8'h02, 1, 1, 0, 0, 8'd4);
        step(0, 0, 0, 1, 8'd81,  8'h02, 1, 1, 0, 0, 8'd5);
        step(0, 0, 0, 1, 8'd243, 8'h02, 1, 1, 0, 0, 8'd6);
        step(0, 0, 0, 0, 8'd0,   8'h02, 1, 1, 0, 0, 8'd6);
        step(0, 0, 0, 1, 8'd217, 8'h02, 1, 1, 0, 0, 8'd7);
        step(0, 0, 0, 1, 8'd139, 8'h02, 1, 1, 0, 0, 8'd8);

        // Reset mid-stream beats clear and a sample
        step(0, 1, 1, 1, 8'd243, 8'hFF, 0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 1, 8'd2,   8'hA0, 0, 0, 0, 0, 8'd1);
        step(0, 1, 0, 1, 8'd3,   8'hFF, 0, 0, 0, 0, 8'd0);

        // Long squares stream: term_count saturates at 255
        for (int i = 0; i < 258; i++) begin
            sq = 8'(i * i);
            ec = (i >= 254) ? 8'd255 : 8'(i + 1);
            step(0, 0, 0, 1, sq, (i < 2) ? 8'h15 : 8'h01, 0, (i >= 3) ? 1'b1 : 1'b0, 0, 0, ec);
        end

        // LOCK_TERMS=1 instance
        step(1, 0, 0, 1, 8'd43,  8'h00, 0, 0, 1, 1, 8'd1);
        step(1, 0, 0, 0, 8'd0,   8'h00, 0, 0, 1, 0, 8'd1);
        step(1, 1, 0, 0, 8'd0,   8'hFF, 0, 0, 0, 0, 8'd0);
        step(1, 0, 0, 1, 8'd2,   8'hA0, 0, 0, 0, 0, 8'd1);
        step(1, 0, 0, 1, 8'd3,   8'h80, 7, 1, 0, 0, 8'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_identifier.md
SEQ_IDENTIFIER -- requirements
Module: seq_identifier

Interface
REQ-001 SHALL have parameter LOCK_TERMS, default 4, meaning the minimum number of accepted samples before the lock output may assert (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port clear, input, 1 bit: synchronous restart of identification.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data holds a sample this cycle.
REQ-006 SHALL have port in_data, input, 8 bits: received sequence term.
REQ-007 SHALL have port match_mask, output, 8 bits: one bit per candidate sequence still consistent with the stream.
REQ-008 SHALL have port seq_id, output, 3 bits: identified sequence index.
REQ-009 SHALL have port locked, output, 1 bit: stream identified.
REQ-010 SHALL have port fail, output, 1 bit: no candidate remains (sticky).
REQ-011 SHALL have port err_pulse, output, 1 bit: single-cycle pulse when match_mask becomes zero.
REQ-012 SHALL have port term_count, output, 8 bits: number of accepted samples.

Function
REQ-013 SHALL hold eight predictors, each producing the expected value of term n (n = 0 at start), all arithmetic mod 256:
  0 squares n^2: 0,1,4,9; 1 powers of 3: 1,3,9,27; 2 triangular n(n+1)/2: 0,1,3,6; 3 Fibonacci: 1,1,2,3; 4 Pell a(n)=2a(n-1)+a(n-2): 0,1,2,5; 5 Lucas: 2,1,3,4; 6 Padovan a(n)=a(n-2)+a(n-3): 1,1,1,2,2,3; 7 Sylvester s(n+1)=s(n)*(s(n)-1)+1: 2,3,7,43,15.
REQ-014 SHALL accept a sample on every cycle with in_valid=1 and not in FAIL; in_valid=0 cycles SHALL leave all state unchanged.
REQ-015 On an accepted sample, SHALL clear match_mask[i] when in_data differs from predictor i's current expected value, and SHALL then advance all predictors one term.
REQ-016 On an accepted sample, SHALL increment term_count, saturating at 255.
REQ-017 All outputs SHALL be registered; the effect of a sample SHALL be visible the cycle after acceptance (latency 1).
REQ-018 SHALL implement states HUNT, LOCKED, FAIL.
REQ-019 HUNT -> LOCKED when the updated match_mask has exactly one bit set and the updated term_count >= LOCK_TERMS.
REQ-020 HUNT or LOCKED -> FAIL when the updated match_mask is zero.
REQ-021 In LOCKED, a matching sample SHALL stay LOCKED; a mismatching sample SHALL go to FAIL.
REQ-022 FAIL SHALL be left only by clear or reset; samples in FAIL SHALL be ignored; term_count and match_mask SHALL hold.
REQ-023 locked SHALL be 1 only in LOCKED; fail SHALL be 1 only in FAIL.
REQ-024 seq_id SHALL equal the index of the set match_mask bit while locked, and SHALL be 0 otherwise.
REQ-025 err_pulse SHALL be 1 for exactly the one cycle following the sample that zeroed match_mask.
REQ-026 clear SHALL have the same effect as reset and SHALL take priority over a simultaneous in_valid; the sample is discarded.

Reset
REQ-027 Reset or clear SHALL set: state HUNT, match_mask=8'hFF, seq_id=0, locked=0, fail=0, err_pulse=0, term_count=0, and all predictors to term 0.
REQ-028 Reset SHALL take priority over clear and in_valid, including in the middle of a stream.

Verification
REQ-029 Samples 0,1,4,9 -> mask 0x15, 0x15, 0x01, 0x01; locked=1, seq_id=0, term_count=4 after the fourth sample.
REQ-030 Samples 2,3,7,43,15 -> mask 0xA0 then 0x80; locked after the fourth sample, seq_id=7; stays locked after 15.
REQ-031 Samples 1,1,2,4 -> mask 0x4A, 0x48, 0x08, then 0x00; fail=1, err_pulse high one cycle, later samples ignored.
REQ-032 Samples 1,3,9,27,81,243,217,139 with idle gaps between samples -> locked, seq_id=1, term_count=8; gaps do not advance the predictors.
REQ-033 clear asserted together with in_valid while LOCKED -> next cycle mask=0xFF, term_count=0, locked=0; the sample is discarded.
REQ-034 LOCK_TERMS=1 with sample 43 -> mask=0x00, fail=1; with samples 2,3 -> locked after the second sample.
